// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V core: opcode constants,
// instruction field bit positions, fetch FSM encoding and reset vector.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Instruction field bit positions
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_FULL = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage. Keeps the fetch PC,
// issues one memory read per instruction, holds the returned word for decode
// behind a valid/ready handshake, and flushes on branch/jump redirects.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] w_fpc_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_nxt;
    logic            r_req;
    logic            w_req_nxt;
    logic            r_discard;
    logic            w_discard_nxt;
    logic            w_capture;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC, request strobe/address, discard flag and held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc     <= RESET_PC;
            r_addr    <= RESET_PC;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_inst    <= '0;
            r_pc      <= '0;
        end else begin
            r_fpc     <= w_fpc_nxt;
            r_addr    <= w_addr_nxt;
            r_req     <= w_req_nxt;
            r_discard <= w_discard_nxt;
            if (w_capture) begin
                r_inst <= imem_rdata;
                r_pc   <= r_fpc;
            end
        end
    end

    // Next-state and control decode; redirect outranks rvalid and the handshake
    always_comb begin
        w_state_nxt   = r_state;
        w_fpc_nxt     = r_fpc;
        w_addr_nxt    = r_addr;
        w_req_nxt     = 1'b0;
        w_discard_nxt = r_discard;
        w_capture     = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                // A redirect here only updates the PC; en is looked at next cycle
                if (redirect) begin
                    w_fpc_nxt = w_redirect_pc;
                end else if (en) begin
                    w_state_nxt = FETCH_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_fpc;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect || r_discard) begin
                        // Stale or flushed response: drop it and refetch at the current target
                        w_discard_nxt = 1'b0;
                        w_fpc_nxt     = redirect ? w_redirect_pc : r_fpc;
                        if (en) begin
                            w_req_nxt  = 1'b1;
                            w_addr_nxt = w_fpc_nxt;
                        end else begin
                            w_state_nxt = FETCH_IDLE;
                        end
                    end else begin
                        w_capture   = 1'b1;
                        w_fpc_nxt   = r_fpc + XLEN'(4);
                        w_state_nxt = FETCH_FULL;
                    end
                end else if (redirect) begin
                    w_discard_nxt = 1'b1;
                    w_fpc_nxt     = w_redirect_pc;
                end
            end
            FETCH_FULL: begin
                if (redirect) begin
                    w_fpc_nxt = w_redirect_pc;
                    if (en) begin
                        w_state_nxt = FETCH_WAIT;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_redirect_pc;
                    end else begin
                        w_state_nxt = FETCH_IDLE;
                    end
                end else if (inst_ready) begin
                    if (en) begin
                        w_state_nxt = FETCH_WAIT;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_fpc;
                    end else begin
                        w_state_nxt = FETCH_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = (r_state == FETCH_FULL);
    assign inst       = r_inst;
    assign pc         = r_pc;
    assign opcode     = r_inst[OPCODE_MSB:OPCODE_LSB];
    assign rd         = r_inst[RD_MSB:RD_LSB];
    assign funct3     = r_inst[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1        = r_inst[RS1_MSB:RS1_LSB];
    assign rs2        = r_inst[RS2_MSB:RS2_LSB];
    assign funct7     = r_inst[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run checked against a program-order fetch model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          rand_lat = 1'b0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } rsp_t;
    rsp_t rq[$];

    instruction_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .pc          (pc),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Instruction memory: answers each request after its latency, shares rst_n
    always @(negedge clk or negedge rst_n) begin : responder
        rsp_t r;
        if (!rst_n) begin
            rq.delete();
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rq[0].addr);
                void'(rq.pop_front());
            end
            if (imem_req) begin
                r.due  = cyc + (rand_lat ? $urandom_range(1, 4) : lat);
                r.addr = imem_addr;
                rq.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int unsigned maxc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_req(input int unsigned maxc, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes: req/valid=%b expected 00", {imem_req, inst_valid});
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00000000", imem_addr);
        end
        checks++;
        if ({inst, pc} !== 64'h0) begin
            errors++;
            $display("FAIL reset_inst_pc: inst=%h pc=%h expected 0", inst, pc);
        end
        checks++;
        if ({opcode, rd, funct3, rs1, rs2, funct7} !== 32'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", {opcode, rd, funct3, rs1, rs2, funct7});
        end
    endtask

    task automatic test_first_fetch();
        mem[32'h0] = 32'h0020_81B3;
        rand_lat = 1'b0;
        lat = 1;
        do_reset();
        en = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h expected 1 / 00000000", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_wait: valid=%b req=%b expected 0 0", inst_valid, imem_req);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0020_81B3) begin
            errors++;
            $display("FAIL first_valid: valid=%b pc=%h inst=%h expected 1 00000000 002081b3",
                     inst_valid, pc, inst);
        end
        checks++;
        if ({opcode, rd, rs1, rs2, funct3, funct7} !== {7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0}) begin
            errors++;
            $display("FAIL first_fields: op=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%0d expected 0110011 3 1 2 0 0",
                     opcode, rd, rs1, rs2, funct3, funct7);
        end
    endtask

    task automatic test_stream();
        logic [31:0] req_addr[$];
        int unsigned req_cyc[$];
        int unsigned val_cyc[$];
        logic [31:0] val_pc[$];
        rand_lat = 1'b0;
        lat = 2;
        do_reset();
        en = 1'b1;
        inst_ready = 1'b1;
        for (int unsigned k = 1; k <= 24; k++) begin
            tick();
            if (imem_req) begin
                req_addr.push_back(imem_addr);
                req_cyc.push_back(k);
            end
            if (inst_valid) begin
                val_cyc.push_back(k);
                val_pc.push_back(pc);
            end
        end
        checks++;
        if (req_addr.size() < 4 || val_cyc.size() < 4) begin
            errors++;
            $display("FAIL stream_count: reqs=%0d valids=%0d expected >=4", req_addr.size(), val_cyc.size());
        end else begin
            checks++;
            if (req_cyc[0] != 1) begin
                errors++;
                $display("FAIL stream_first_req_cycle: got %0d expected 1", req_cyc[0]);
            end
            for (int unsigned i = 0; i < 4; i++) begin
                checks++;
                if (req_addr[i] !== 32'(4 * i) || val_pc[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL stream_addr%0d: req=%h pc=%h expected %h", i, req_addr[i], val_pc[i], 32'(4 * i));
                end
                if (i > 0) begin
                    checks++;
                    if (val_cyc[i] - val_cyc[i-1] != 4) begin
                        errors++;
                        $display("FAIL stream_spacing%0d: got %0d expected 4", i, val_cyc[i] - val_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] p;
        logic [31:0] w;
        rand_lat = 1'b0;
        lat = $urandom_range(1, 3);
        do_reset();
        en = 1'b1;
        inst_ready = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: inst_valid=0 expected 1 within 20 cycles");
        end
        p = pc;
        w = inst;
        checks++;
        if (p !== 32'h0 || w !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL bp_first: pc=%h inst=%h expected 00000000 %h", p, w, mem_word(32'h0));
        end
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({inst_valid, imem_req, inst, pc} !== {1'b1, 1'b0, w, p}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b req=%b inst=%h pc=%h expected 1 0 %h %h",
                         i, inst_valid, imem_req, inst, pc, w, p);
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== p + 32'd4 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_req: req=%b addr=%h valid=%b expected 1 %h 0",
                     imem_req, imem_addr, inst_valid, p + 32'd4);
        end
    endtask

    task automatic test_redirect_inflight();
        bit ok;
        bit got_req;
        bit got_val;
        int unsigned t;
        int unsigned req_off;
        logic [31:0] req_a;
        logic [31:0] v_pc;
        logic [31:0] v_inst;
        rand_lat = 1'b0;
        lat = 3;
        do_reset();
        en = 1'b1;
        inst_ready = 1'b1;
        wait_req(10, ok);
        t = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rdi_timeout: imem_req=0 expected 1 within 10 cycles");
        end
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        got_req = 1'b0;
        got_val = 1'b0;
        req_off = 0;
        req_a = '0;
        v_pc = '0;
        v_inst = '0;
        for (int unsigned k = 0; k < 20 && !got_val; k++) begin
            if (imem_req && !got_req) begin
                got_req = 1'b1;
                req_a = imem_addr;
                req_off = cyc - t;
            end
            if (inst_valid) begin
                got_val = 1'b1;
                v_pc = pc;
                v_inst = inst;
            end
            if (!got_val) tick();
        end
        checks++;
        if (!got_req || req_a !== 32'h100 || req_off != 4) begin
            errors++;
            $display("FAIL rdi_req: seen=%b addr=%h offset=%0d expected 1 00000100 4", got_req, req_a, req_off);
        end
        checks++;
        if (!got_val || v_pc !== 32'h100 || v_inst !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL rdi_deliver: seen=%b pc=%h inst=%h expected 1 00000100 %h",
                     got_val, v_pc, v_inst, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_full();
        bit ok;
        logic [31:0] rpc;
        logic [31:0] exp_a;
        rand_lat = 1'b0;
        lat = $urandom_range(1, 4);
        do_reset();
        en = 1'b1;
        inst_ready = 1'b0;
        wait_valid(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rdf_timeout: inst_valid=0 expected 1 within 20 cycles");
        end
        rpc = $urandom;
        rpc[0] = 1'b1;
        exp_a = rpc - (rpc % 4);
        redirect = 1'b1;
        redirect_pc = rpc;
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_a) begin
            errors++;
            $display("FAIL rdf_next: valid=%b req=%b addr=%h expected 0 1 %h", inst_valid, imem_req, imem_addr, exp_a);
        end
        inst_ready = 1'b1;
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== exp_a || inst !== mem_word(exp_a)) begin
            errors++;
            $display("FAIL rdf_deliver: seen=%b pc=%h inst=%h expected 1 %h %h", ok, pc, inst, exp_a, mem_word(exp_a));
        end
    endtask

    task automatic test_async_reset_wrap();
        bit ok;
        rand_lat = 1'b0;
        lat = 3;
        do_reset();
        en = 1'b1;
        inst_ready = 1'b1;
        wait_valid(20, ok);
        tick();
        wait_valid(20, ok);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, inst_valid} !== 2'b00 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_ctrl: req=%b valid=%b addr=%h expected 0 0 00000000", imem_req, inst_valid, imem_addr);
        end
        checks++;
        if ({inst, pc} !== 64'h0 || {opcode, rd, funct3, rs1, rs2, funct7} !== 32'h0) begin
            errors++;
            $display("FAIL areset_data: inst=%h pc=%h expected 0 0", inst, pc);
        end
        en = 1'b0;
        inst_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        en = 1'b1;
        inst_ready = 1'b1;
        wait_req(10, ok);
        checks++;
        if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req0: seen=%b addr=%h expected 1 fffffffc", ok, imem_addr);
        end
        wait_valid(20, ok);
        checks++;
        if (!ok || pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_deliver: seen=%b pc=%h expected 1 fffffffc", ok, pc);
        end
        tick();
        wait_req(10, ok);
        checks++;
        if (!ok || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req1: seen=%b addr=%h expected 1 00000000", ok, imem_addr);
        end
    endtask

    // Random en/ready/redirect/latency; delivered stream must follow program order
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] e;
        int unsigned outstanding;
        int unsigned delivered;
        rand_lat = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        prev_addr = imem_addr;
        outstanding = 0;
        delivered = 0;
        for (int unsigned k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            redirect = redirect ? 1'b0 : ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            @(negedge clk);
            #1;
            if (imem_req) begin
                checks++;
                if (outstanding != 0 || imem_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_req@%0d: outstanding=%0d addr=%h expected 0 %h", k, outstanding, imem_addr, exp_pc);
                end
                outstanding = 1;
            end else begin
                checks++;
                if (imem_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_addr_hold@%0d: addr=%h expected %h", k, imem_addr, prev_addr);
                end
            end
            prev_addr = imem_addr;
            if (imem_rvalid) outstanding = 0;
            if (redirect) begin
                exp_pc = redirect_pc - (redirect_pc % 4);
            end else if (inst_valid && inst_ready) begin
                e = mem_word(exp_pc);
                checks++;
                if (pc !== exp_pc || inst !== e) begin
                    errors++;
                    $display("FAIL rnd_deliver@%0d: pc=%h inst=%h expected %h %h", k, pc, inst, exp_pc, e);
                end
                checks++;
                if (opcode !== 7'(e % 128) || rd !== 5'((e / 128) % 32) || funct3 !== 3'((e / 4096) % 8) ||
                    rs1 !== 5'((e / 32768) % 32) || rs2 !== 5'((e / 1048576) % 32) || funct7 !== 7'(e / 33554432)) begin
                    errors++;
                    $display("FAIL rnd_fields@%0d: op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h for inst %h",
                             k, opcode, rd, funct3, rs1, rs2, funct7, e);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            @(posedge clk);
            #1;
        end
        redirect = 1'b0;
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rnd_progress: delivered=%0d expected >=100", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_full();
        test_async_reset_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Single-outstanding-request instruction fetch stage that sits directly upstream of `control_unit` in the multi-cycle RISC-V core. It keeps the PC and issues one read per instruction to instruction memory. It registers the returned word and presents it, already sliced into `opcode`/`funct3`/`funct7`/`rd`/`rs1`/`rs2`, to the decode stage over a valid/ready handshake. Branch/jump redirects flush any held or in-flight instruction.

## Interface
Parameters:
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  fetch enable; 0 blocks new requests only.
- `redirect`  in  1  one-cycle pulse: replace PC and flush.
- `redirect_pc`  in  XLEN  new PC; bits [1:0] ignored, forced 0.
- `imem_req`  out  1  registered one-cycle read strobe.
- `imem_addr`  out  XLEN  registered word address, valid with `imem_req`.
- `imem_rvalid`  in  1  read data valid, at least 1 cycle after `imem_req`.
- `imem_rdata`  in  XLEN  instruction word.
- `inst_valid`  out  1  held instruction valid.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  XLEN  held instruction word.
- `pc`  out  XLEN  address of `inst`.
- `opcode`  out  7  `inst[6:0]`.
- `rd`  out  5  `inst[11:7]`.
- `funct3`  out  3  `inst[14:12]`.
- `rs1`  out  5  `inst[19:15]`.
- `rs2`  out  5  `inst[24:20]`.
- `funct7`  out  7  `inst[31:25]`.

## Operation
- FSM states: IDLE, WAIT, FULL. Reset enters IDLE.
- Internal fetch PC `fpc` resets to `RESET_PC`.
- IDLE:
  - `en`=1 → WAIT, issuing a request at `fpc`.
  - `redirect` → `fpc`←`redirect_pc`, then evaluates `en` on the following cycle.
- WAIT:
  - `imem_req`=1 only in the first WAIT cycle.
  - On `imem_rvalid` with `discard`=0: capture `imem_rdata` into `inst` and `fpc` into `pc`; `fpc`←`fpc`+4 (mod 2^32); → FULL.
- FULL:
  - `inst_valid`=1.
  - On `inst_valid`&`inst_ready`: → WAIT if `en`, else → IDLE.
- Redirect has priority over the handshake and over `imem_rvalid`.
  - FULL: `inst_valid` drops next cycle and the instruction is lost. → WAIT at `redirect_pc` if `en`, else IDLE.
  - WAIT with a request in flight: set `discard`. The matching `imem_rvalid` is dropped, then a new request is issued at `redirect_pc`.
  - WAIT in the same cycle as `imem_rvalid`: drop the data, no `discard`; issue a new request next cycle.
- `en` falling while in WAIT: the outstanding response is still delivered to FULL; no further requests.
- `imem_rvalid` in IDLE or FULL: ignored.
- Held outputs are stable while `inst_valid`&!`inst_ready`.
- Field outputs are pure slices of the `inst` register; no extra logic.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=0, `pc`=0, all fields 0, `discard`=0.
- Reset is asynchronous and immediate mid-operation.
  - Instruction memory shares `rst_n`, so no responses to pre-reset requests arrive.
- Fetch latency: `imem_req` at cycle t, `imem_rvalid` at t+L (L≥1), `inst_valid` at t+L+1.
- After handshake at cycle u, the next `imem_req` is at u+1. Throughput is one instruction per L+2 cycles.
- After `redirect` at cycle r, the next `imem_req` is at r+1, or after the stale response if `discard` is set.
- `imem_addr` changes only in `imem_req` cycles.

## Structure
- Shared `riscv_pkg`:
  - `OPC_RTYPE`=7'b0110011 and the other opcode constants.
  - Instruction field bit positions.
  - Fetch FSM state encoding.
  - `RESET_PC` default.
- `control_unit` imports the same package.
- Single module. Field slicing is too thin for a sub-module.

## Test plan
- **Reset/first fetch**: release `rst_n`, `en`=1, memory L=1 returns 32'h0020_81B3 → `imem_req` at cycle 1 with addr 0; `inst_valid` at cycle 3 with `pc`=0, `opcode`=7'b0110011, `rd`=3, `rs1`=1, `rs2`=2, `funct3`=0, `funct7`=0.
- **Stream**: `inst_ready`=1, L=2, 4 instructions → addrs 0,4,8,12; `inst_valid` pulses every 4 cycles.
- **Backpressure**: `inst_ready`=0 for 5 cycles → `inst`/`pc` stable, no `imem_req`; next request one cycle after ready.
- **Redirect in flight**: redirect to 32'h100 during WAIT with L=3 → stale `rdata` never reaches `inst_valid`; next `imem_req` addr 32'h100; delivered `pc`=32'h100.
- **Redirect in FULL with simultaneous ready**: → no handshake counted; `inst_valid` low next cycle; next fetch at `redirect_pc` & ~3.
- **Async reset mid-WAIT, and wrap**: assert `rst_n` low → outputs reset immediately. Redirect to 32'hFFFF_FFFC → following fetch addr 0.
